prometheus_fx3_burst_loopback: RTL and testbench

PROMETHEUS_FX3_BURST_LOOPBACK -- requirements
Module: prometheus_fx3_burst_loopback

---
 rtl/prometheus_fx3_pkg.sv | 39 +++
 rtl/prometheus_sync_fifo.sv | 62 ++++++
 rtl/prometheus_fx3_burst_loopback.sv | 162 ++++++++++++++++
 tb/tb_prometheus_fx3_burst_loopback.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prometheus_fx3_pkg.sv
// Shared definitions for the FX3 burst loopback: default parameters, FSM
// state encoding and the registered strobe bundle decoded from a state.
package prometheus_fx3_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_RD_LAT = 4;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR    = 4'd1,
    WAIT_RD = 4'd2,
    READ    = 4'd3,
    DRAIN   = 4'd4,
    WAIT_WA = 4'd5,
    WAIT_WB = 4'd6,
    WRITE   = 4'd7,
    PKTEND  = 4'd8,
    FLUSH   = 4'd9
  } state_t;

  // Outputs that depend only on the state; registered alongside it.
  typedef struct packed {
    logic oe_n;
    logic pktend_n;
    logic rd_addr_sel;
    logic busy;
  } strb_t;

  function automatic strb_t strb_of(state_t s);
    strb_t r;
    r.oe_n        = !(s == READ || s == DRAIN);
    r.pktend_n    = (s != PKTEND);
    r.rd_addr_sel = (s == ADDR || s == WAIT_RD || s == READ || s == DRAIN);
    r.busy        = (s != IDLE);
    return r;
  endfunction

endpackage

// File: rtl/prometheus_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush and an
// occupancy count. Pushes into a full FIFO and pops from an empty one are
// ignored; a simultaneous push and pop leaves the count unchanged.
module prometheus_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_100,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_100) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/prometheus_fx3_burst_loopback.sv
// FX3 slave-FIFO burst loopback: reads a burst from the consumer socket
// (ch1) into a local buffer, then writes it back to the producer socket
// (ch0) and closes the packet with pktend_n.
// Strobe handshake: a strobe low is a transfer. re_n is driven low only in
// READ while out_ch1_rdy is high and the buffer can still take the word;
// we_n is driven low only in WRITE while out_ch0_rdy is high and the buffer
// holds a word. Both are decoded in the same cycle as the flag, so a strobe
// never fires against a not-ready socket. Read data returns RD_LAT cycles
// after its re_n cycle.
module prometheus_fx3_burst_loopback
  import prometheus_fx3_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_ch0_rdy,
  input  logic              out_ch0_rdy,
  input  logic              in_ch1_rdy,
  input  logic              out_ch1_rdy,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              re_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              pktend_n,
  output logic              rd_addr_sel,
  output logic              busy,
  output logic [15:0]       last_count,
  output logic              overflow_err,
  output state_t            state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state;
  strb_t             strb;
  logic [3:0]        drain_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic [3:0]        inflight;
  logic [15:0]       word_cnt;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              rd_fire;
  logic [31:0]       level;

  // Words already buffered plus reads whose data is still in flight.
  assign level   = 32'(fifo_count) + 32'(inflight);
  assign rd_fire = (state == READ) && out_ch1_rdy && (level < 32'(DEPTH));
  assign push    = rd_pipe[RD_LAT-1];
  assign pop     = (state == WRITE) && out_ch0_rdy && !fifo_empty;

  assign re_n        = !rd_fire;
  assign we_n        = !pop;
  assign oe_n        = strb.oe_n;
  assign pktend_n    = strb.pktend_n;
  assign rd_addr_sel = strb.rd_addr_sel;
  assign busy        = strb.busy;
  assign state_dbg   = state;

  prometheus_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .flush     (state == FLUSH),
    .push      (push),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Transfer sequencer; strobes registered together with the next state.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      strb      <= strb_of(IDLE);
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (enable && in_ch1_rdy) begin
          state <= ADDR;    strb <= strb_of(ADDR);
        end
        ADDR: begin
          state <= WAIT_RD; strb <= strb_of(WAIT_RD);
        end
        WAIT_RD: if (out_ch1_rdy) begin
          state <= READ;    strb <= strb_of(READ);
        end
        READ: if (!out_ch1_rdy || (level + 1 >= 32'(DEPTH))) begin
          state     <= DRAIN; strb <= strb_of(DRAIN);
          drain_cnt <= '0;
        end
        DRAIN: if (drain_cnt == 4'(RD_LAT)) begin
          state <= WAIT_WA; strb <= strb_of(WAIT_WA);
        end else begin
          drain_cnt <= drain_cnt + 4'd1;
        end
        WAIT_WA: if (in_ch0_rdy) begin
          state <= WAIT_WB; strb <= strb_of(WAIT_WB);
        end
        WAIT_WB: if (out_ch0_rdy) begin
          state <= WRITE;   strb <= strb_of(WRITE);
        end
        WRITE: begin
          if (fifo_empty) begin
            // Nothing left: close the packet only if the socket is ready.
            if (out_ch0_rdy) begin
              state <= PKTEND; strb <= strb_of(PKTEND);
            end else begin
              state <= FLUSH;  strb <= strb_of(FLUSH);
            end
          end else if (!out_ch0_rdy) begin
            state <= WAIT_WA;  strb <= strb_of(WAIT_WA);
          end else if (fifo_count == CW'(1)) begin
            state <= PKTEND;   strb <= strb_of(PKTEND);
          end
        end
        PKTEND: begin
          state <= FLUSH;   strb <= strb_of(FLUSH);
        end
        FLUSH: begin
          state <= IDLE;    strb <= strb_of(IDLE);
        end
        default: begin
          state <= IDLE;    strb <= strb_of(IDLE);
        end
      endcase
    end
  end

  // Read-latency pipeline, in-flight tracking, word count and status.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe      <= '0;
      inflight     <= '0;
      word_cnt     <= '0;
      last_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      rd_pipe  <= (rd_pipe << 1) | RD_LAT'(rd_fire);
      inflight <= inflight + 4'(rd_fire) - 4'(push);
      if (state == ADDR)
        word_cnt <= '0;
      else if (push && word_cnt != 16'hFFFF)
        word_cnt <= word_cnt + 16'd1;
      if (push && fifo_full) overflow_err <= 1'b1;
      if (state == FLUSH) last_count <= word_cnt;
    end
  end

endmodule

// File: tb/tb_prometheus_fx3_burst_loopback.sv
// Bench for the FX3 burst loopback. Two instances share all control
// stimulus and differ only in read latency (1 and 8). A behavioural FX3
// read port returns table words RD_LAT cycles after each re_n cycle; every
// word read is queued as expected write data and checked on each we_n cycle.
`timescale 1ns/1ps
module tb_prometheus_fx3_burst_loopback;
  import prometheus_fx3_pkg::*;

  localparam int DW   = 32;
  localparam int DEP  = 16;
  localparam int LAT0 = 1;
  localparam int LAT1 = 8;

  // Clock and shared control
  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic rst_n, enable, in_ch0_rdy, out_ch0_rdy, in_ch1_rdy, out_ch1_rdy;

  logic [DW-1:0] data_in_v  [2];
  logic [DW-1:0] data_out_v [2];
  logic          re_n_v     [2];
  logic          oe_n_v     [2];
  logic          we_n_v     [2];
  logic          pktend_n_v [2];
  logic          sel_v      [2];
  logic          busy_v     [2];
  logic [15:0]   last_v     [2];
  logic          ovf_v      [2];
  state_t        st_v       [2];

  prometheus_fx3_burst_loopback #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(LAT0)) dut0 (
    .clk_100(clk_100), .rst_n(rst_n), .enable(enable),
    .in_ch0_rdy(in_ch0_rdy), .out_ch0_rdy(out_ch0_rdy),
    .in_ch1_rdy(in_ch1_rdy), .out_ch1_rdy(out_ch1_rdy),
    .data_in(data_in_v[0]), .data_out(data_out_v[0]),
    .re_n(re_n_v[0]), .oe_n(oe_n_v[0]), .we_n(we_n_v[0]), .pktend_n(pktend_n_v[0]),
    .rd_addr_sel(sel_v[0]), .busy(busy_v[0]), .last_count(last_v[0]),
    .overflow_err(ovf_v[0]), .state_dbg(st_v[0]));

  prometheus_fx3_burst_loopback #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(LAT1)) dut1 (
    .clk_100(clk_100), .rst_n(rst_n), .enable(enable),
    .in_ch0_rdy(in_ch0_rdy), .out_ch0_rdy(out_ch0_rdy),
    .in_ch1_rdy(in_ch1_rdy), .out_ch1_rdy(out_ch1_rdy),
    .data_in(data_in_v[1]), .data_out(data_out_v[1]),
    .re_n(re_n_v[1]), .oe_n(oe_n_v[1]), .we_n(we_n_v[1]), .pktend_n(pktend_n_v[1]),
    .rd_addr_sel(sel_v[1]), .busy(busy_v[1]), .last_count(last_v[1]),
    .overflow_err(ovf_v[1]), .state_dbg(st_v[1]));

  // Scoreboard and bookkeeping
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] wlog0[$];
  logic [DW-1:0] wlog1[$];
  logic [DW-1:0] word_tab [256];
  logic [DW-1:0] slot_w [2][16];
  logic          slot_v [2][16];
  int rd_idx [2];
  int re_cnt [2];
  int wr_cnt [2];
  int pk_cnt [2];
  int dr_cnt [2];
  int cyc;
  int checks;
  int errors;

  function automatic int lat_of(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // FX3 read port model and write-side monitor, evaluated mid-cycle
  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 16; s++) slot_v[d][s] = 1'b0;
      rd_idx[d] = 0;
    end
    forever begin
      @(negedge clk_100);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        int s;
        s = cyc % 16;
        if (slot_v[d][s]) begin
          data_in_v[d] = slot_w[d][s];
          slot_v[d][s] = 1'b0;
        end else begin
          data_in_v[d] = $urandom;
        end
        if (st_v[d] == ADDR) rd_idx[d] = 0;
        if (re_n_v[d] === 1'b0) begin
          logic [DW-1:0] w;
          w = word_tab[rd_idx[d] % 256];
          rd_idx[d]++;
          slot_w[d][(cyc + lat_of(d)) % 16] = w;
          slot_v[d][(cyc + lat_of(d)) % 16] = 1'b1;
          if (d == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
          re_cnt[d]++;
        end
        if (we_n_v[d] === 1'b0) begin
          logic [DW-1:0] e;
          int left;
          left = (d == 0) ? exp_q0.size() : exp_q1.size();
          checks++;
          if (left == 0) begin
            errors++;
            $display("FAIL sb_write dut%0d: wrote 0x%08h, expected no write", d, data_out_v[d]);
          end else begin
            if (d == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
            if (data_out_v[d] !== e) begin
              errors++;
              $display("FAIL sb_write dut%0d: got 0x%08h expected 0x%08h", d, data_out_v[d], e);
            end
          end
          if (d == 0) wlog0.push_back(data_out_v[d]); else wlog1.push_back(data_out_v[d]);
          wr_cnt[d]++;
        end
        if (pktend_n_v[d] === 1'b0) pk_cnt[d]++;
        if (st_v[d] == DRAIN) dr_cnt[d]++;
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic fill_words();
    for (int i = 0; i < 256; i++) word_tab[i] = $urandom;
  endtask

  task automatic clear_counters();
    for (int d = 0; d < 2; d++) begin
      re_cnt[d] = 0; wr_cnt[d] = 0; pk_cnt[d] = 0; dr_cnt[d] = 0;
    end
    wlog0.delete();
    wlog1.delete();
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk_100); #1;
      if (st_v[0] == READ) ok = 1'b1;
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk_100); #1;
      if (busy_v[0] === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk_100); #1;
      if (st_v[0] == IDLE && st_v[1] == IDLE) ok = 1'b1;
    end
  endtask

  task automatic wait_writes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk_100); #1;
      if (wr_cnt[0] >= n) ok = 1'b1;
    end
  endtask

  // Starts a transfer and allows n read cycles; n < 0 keeps out_ch1_rdy high.
  task automatic start_transfer(input int n, output bit ok);
    bit ok1, ok2;
    fill_words();
    clear_counters();
    in_ch1_rdy  = 1'b1;
    out_ch1_rdy = 1'b1;
    enable      = 1'b1;
    wait_busy(ok1);
    enable = 1'b0;
    wait_read(ok2);
    if (n >= 0) begin
      if (n > 0) begin
        repeat (n) @(posedge clk_100);
        #1;
      end
      out_ch1_rdy = 1'b0;
    end
    ok = ok1 && ok2;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_100);
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [6:0] got;
      got = {re_n_v[d], oe_n_v[d], we_n_v[d], pktend_n_v[d], sel_v[d], busy_v[d], ovf_v[d]};
      checks++;
      if (got !== 7'b1111000) begin
        errors++;
        $display("FAIL reset_strobes dut%0d: got %b expected 1111000", d, got);
      end
      checks++;
      if (last_v[d] !== 16'd0) begin
        errors++;
        $display("FAIL reset_last dut%0d: got %0d expected 0", d, last_v[d]);
      end
      checks++;
      if (st_v[d] != IDLE) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %0d expected %0d", d, st_v[d], IDLE);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk_100);
    #1;
  endtask

  task automatic test_basic_loop();
    bit ok;
    start_transfer(10, ok);
    if (ok) wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done: transfer did not return to IDLE, expected completion");
    end
    for (int d = 0; d < 2; d++) begin
      int left;
      left = (d == 0) ? exp_q0.size() : exp_q1.size();
      checks++;
      if (re_cnt[d] != 10) begin errors++; $display("FAIL basic_reads dut%0d: got %0d expected 10", d, re_cnt[d]); end
      checks++;
      if (wr_cnt[d] != 10) begin errors++; $display("FAIL basic_writes dut%0d: got %0d expected 10", d, wr_cnt[d]); end
      checks++;
      if (pk_cnt[d] != 1) begin errors++; $display("FAIL basic_pktend dut%0d: got %0d expected 1", d, pk_cnt[d]); end
      checks++;
      if (last_v[d] !== 16'd10) begin errors++; $display("FAIL basic_last dut%0d: got %0d expected 10", d, last_v[d]); end
      checks++;
      if (left != 0) begin errors++; $display("FAIL basic_leftover dut%0d: got %0d expected 0", d, left); end
    end
  endtask

  task automatic test_latency();
    bit ok;
    bit same;
    int n;
    n = $urandom_range(3, 9);
    start_transfer(n, ok);
    if (ok) wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL latency_done: transfer did not return to IDLE, expected completion");
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dr_cnt[d] != lat_of(d) + 1) begin
        errors++;
        $display("FAIL latency_drain dut%0d: got %0d cycles expected %0d", d, dr_cnt[d], lat_of(d) + 1);
      end
    end
    same = (wlog0.size() == n) && (wlog1.size() == n);
    if (same) for (int i = 0; i < n; i++) if (wlog0[i] !== wlog1[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL latency_identical: sizes %0d/%0d, expected %0d identical words", wlog0.size(), wlog1.size(), n);
    end
  endtask

  task automatic test_depth_limit();
    bit ok;
    start_transfer(-1, ok);
    if (ok) wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL depth_done: transfer did not return to IDLE, expected completion");
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (re_cnt[d] != DEP) begin errors++; $display("FAIL depth_reads dut%0d: got %0d expected %0d", d, re_cnt[d], DEP); end
      checks++;
      if (wr_cnt[d] != DEP) begin errors++; $display("FAIL depth_writes dut%0d: got %0d expected %0d", d, wr_cnt[d], DEP); end
      checks++;
      if (ovf_v[d] !== 1'b0) begin errors++; $display("FAIL depth_overflow dut%0d: got %b expected 0", d, ovf_v[d]); end
      checks++;
      if (last_v[d] !== 16'(DEP)) begin errors++; $display("FAIL depth_last dut%0d: got %0d expected %0d", d, last_v[d], DEP); end
    end
  endtask

  task automatic test_write_stall();
    bit ok;
    start_transfer(12, ok);
    if (ok) wait_writes(5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_start: writes did not reach 5, expected 5");
    end
    out_ch0_rdy = 1'b0;
    repeat (20) @(posedge clk_100);
    #1;
    checks++;
    if (wr_cnt[0] != 5) begin errors++; $display("FAIL stall_hold: got %0d writes expected 5", wr_cnt[0]); end
    checks++;
    if (st_v[0] != WAIT_WB) begin errors++; $display("FAIL stall_state: got %0d expected %0d", st_v[0], WAIT_WB); end
    out_ch0_rdy = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_done: transfer did not return to IDLE, expected completion");
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wr_cnt[d] != 12) begin errors++; $display("FAIL stall_writes dut%0d: got %0d expected 12", d, wr_cnt[d]); end
      checks++;
      if (pk_cnt[d] != 1) begin errors++; $display("FAIL stall_pktend dut%0d: got %0d expected 1", d, pk_cnt[d]); end
      checks++;
      if (last_v[d] !== 16'd12) begin errors++; $display("FAIL stall_last dut%0d: got %0d expected 12", d, last_v[d]); end
    end
  endtask

  task automatic test_reset_in_write();
    bit ok;
    start_transfer(10, ok);
    if (ok) wait_writes(4, ok);
    checks++;
    if (!ok || st_v[0] != WRITE) begin
      errors++;
      $display("FAIL rstw_setup: state %0d writes %0d, expected WRITE after 4 writes", st_v[0], wr_cnt[0]);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [6:0] got;
      got = {re_n_v[d], oe_n_v[d], we_n_v[d], pktend_n_v[d], sel_v[d], busy_v[d], ovf_v[d]};
      checks++;
      if (got !== 7'b1111000) begin
        errors++;
        $display("FAIL rstw_strobes dut%0d: got %b expected 1111000", d, got);
      end
      checks++;
      if (last_v[d] !== 16'd0) begin
        errors++;
        $display("FAIL rstw_last dut%0d: got %0d expected 0", d, last_v[d]);
      end
      checks++;
      if (st_v[d] != IDLE) begin
        errors++;
        $display("FAIL rstw_state dut%0d: got %0d expected %0d", d, st_v[d], IDLE);
      end
    end
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) for (int s = 0; s < 16; s++) slot_v[d][s] = 1'b0;
    repeat (2) @(posedge clk_100);
    #1;
    rst_n = 1'b1;
    @(posedge clk_100);
    #1;
    start_transfer(5, ok);
    if (ok) wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstw_done: transfer did not return to IDLE, expected completion");
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wr_cnt[d] != 5) begin errors++; $display("FAIL rstw_writes dut%0d: got %0d expected 5", d, wr_cnt[d]); end
      checks++;
      if (last_v[d] !== 16'd5) begin errors++; $display("FAIL rstw_last2 dut%0d: got %0d expected 5", d, last_v[d]); end
    end
  endtask

  task automatic test_zero_word();
    bit ok;
    start_transfer(0, ok);
    if (ok) wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_done: transfer did not return to IDLE, expected completion");
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (re_cnt[d] != 0) begin errors++; $display("FAIL zero_reads dut%0d: got %0d expected 0", d, re_cnt[d]); end
      checks++;
      if (wr_cnt[d] != 0) begin errors++; $display("FAIL zero_writes dut%0d: got %0d expected 0", d, wr_cnt[d]); end
      checks++;
      if (pk_cnt[d] != 1) begin errors++; $display("FAIL zero_pktend dut%0d: got %0d expected 1", d, pk_cnt[d]); end
      checks++;
      if (last_v[d] !== 16'd0) begin errors++; $display("FAIL zero_last dut%0d: got %0d expected 0", d, last_v[d]); end
    end
  endtask

  // Sequence and report
  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    in_ch0_rdy  = 1'b1;
    out_ch0_rdy = 1'b1;
    in_ch1_rdy  = 1'b0;
    out_ch1_rdy = 1'b0;
    fill_words();
    clear_counters();
    test_reset();
    test_basic_loop();
    test_latency();
    test_depth_limit();
    test_write_stall();
    test_reset_in_write();
    test_zero_word();
    repeat (5) @(posedge clk_100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
